// File: rtl/prim_reqack_pkg.sv
// Shared types and sizing helpers for the req/ack initiator and its request buffer.
package prim_reqack_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO used as the initiator's request buffer.
// Storage is reset to zero so the head output is defined after reset.
module fifo_v3
   import prim_reqack_pkg::*;
#(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 2,
   localparam int unsigned AddrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CntW        = cnt_width(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [CntW-1:0]       usage_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam logic [AddrW-1:0] LastAddr = AddrW'(DEPTH - 1);
   localparam logic [CntW-1:0]  FullCnt  = CntW'(DEPTH);

   logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]       usage_q, usage_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  mem_we;

   assign full_o  = (usage_q == FullCnt);
   assign empty_o = (usage_q == '0);
   assign usage_o = usage_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      usage_d  = usage_q;
      mem_we   = 1'b0;
      data_o   = mem_q[rd_ptr_q];

      if (push_i && !full_o) begin
         mem_we   = 1'b1;
         wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + AddrW'(1);
         usage_d  = usage_d + CntW'(1);
      end
      if (pop_i && !empty_o) begin
         rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + AddrW'(1);
         usage_d  = usage_d - CntW'(1);
      end

      // Bypass an empty buffer; a same-cycle pop consumes the word without storing it.
      if (FALL_THROUGH && empty_o && push_i) begin
         data_o = data_i;
         if (pop_i) begin
            mem_we   = 1'b0;
            wr_ptr_d = wr_ptr_q;
            usage_d  = usage_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         usage_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         usage_q  <= usage_d;
         if (mem_we) begin
            mem_q[wr_ptr_q] <= data_i;
         end
      end
   end

endmodule

// File: rtl/prim_reqack_initiator.sv
// Buffers upstream transactions and presents them one at a time on a req/ack
// handshake toward a synchronizer, with an optional sticky no-ack timeout flag.
module prim_reqack_initiator
   import prim_reqack_pkg::*;
#(
   parameter int unsigned Width         = 32,
   parameter int unsigned Depth         = 2,
   parameter int unsigned TimeoutCycles = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   output logic             req_o,
   input  logic             ack_i,
   output logic [Width-1:0] data_o,
   output logic             done_o,
   output logic             busy_o,
   output logic             timeout_o,
   input  logic             clr_timeout_i
);

   localparam int unsigned CntW = cnt_width(Depth);

   state_e            state_q, state_d;
   logic [CntW-1:0]   count;
   logic              fifo_full, fifo_empty;
   logic              push, pop;

   assign in_ready_o = ~fifo_full;
   assign push       = in_valid_i & in_ready_o;
   assign pop        = (state_q == REQ) & ack_i;

   fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DATA_WIDTH   (Width),
      .DEPTH        (Depth)
   ) u_req_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .usage_o (count),
      .data_i  (in_data_i),
      .push_i  (push),
      .data_o  (data_o),
      .pop_i   (pop)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (!fifo_empty || push) state_d = REQ;
         // Keep REQ up across the ack whenever another word is (or is becoming) available.
         REQ:  if (ack_i) state_d = ((count > CntW'(1)) || push) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign req_o  = (state_q == REQ);
   assign done_o = pop;
   assign busy_o = ~fifo_empty | req_o;

   if (TimeoutCycles > 0) begin : g_timer
      localparam int unsigned      TmrW   = cnt_width(TimeoutCycles);
      localparam logic [TmrW-1:0] TMax   = TmrW'(TimeoutCycles);
      localparam logic [TmrW-1:0] TMaxM1 = TmrW'(TimeoutCycles - 1);

      logic [TmrW-1:0] tmr_q, tmr_d;
      logic            reach_q, reach_d;
      logic            timeout_q, timeout_d;

      // reach marks the single edge at which the counter saturates, so a cleared
      // flag is not re-armed while the same request keeps waiting.
      always_comb begin
         tmr_d   = tmr_q;
         reach_d = 1'b0;
         if (state_q == IDLE && state_d == REQ) begin
            tmr_d = '0;
         end else if (state_q == REQ) begin
            if (ack_i) begin
               tmr_d = '0;
            end else if (tmr_q != TMax) begin
               tmr_d   = tmr_q + TmrW'(1);
               reach_d = (tmr_q == TMaxM1);
            end
         end
         timeout_d = reach_q ? 1'b1 : (clr_timeout_i ? 1'b0 : timeout_q);
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            tmr_q     <= '0;
            reach_q   <= 1'b0;
            timeout_q <= 1'b0;
         end else begin
            tmr_q     <= tmr_d;
            reach_q   <= reach_d;
            timeout_q <= timeout_d;
         end
      end

      assign timeout_o = timeout_q;
   end else begin : g_no_timer
      logic unused_clr_timeout;
      assign unused_clr_timeout = clr_timeout_i;
      assign timeout_o          = 1'b0;
   end

   data_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_o && !ack_i) |=> $stable(data_o));

   in_data_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (in_valid_i && !in_ready_o) |=> $stable(in_data_i));

endmodule

// File: tb/tb_prim_reqack_initiator.sv
// Directed bench for prim_reqack_initiator: vector table plus timeout and reset sequences.
module tb_prim_reqack_initiator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        req;
   logic        ack;
   logic [31:0] data;
   logic        done;
   logic        busy;
   logic        timeout;
   logic        clr_timeout;

   int checks = 0;
   int errors = 0;

   prim_reqack_initiator #(
      .Width         (32),
      .Depth         (2),
      .TimeoutCycles (4)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_data_i     (in_data),
      .req_o         (req),
      .ack_i         (ack),
      .data_o        (data),
      .done_o        (done),
      .busy_o        (busy),
      .timeout_o     (timeout),
      .clr_timeout_i (clr_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [31:0] din;
      logic        ack;
      logic        rdy;
      logic        req;
      logic        chk_data;
      logic [31:0] dout;
      logic        done;
      logic        busy;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic vld, input logic [31:0] din, input logic a,
                               input logic rdy, input logic rq, input logic cd,
                               input logic [31:0] dout, input logic dn, input logic bz);
      vec_t v;
      v.vld = vld; v.din = din; v.ack = a; v.rdy = rdy; v.req = rq;
      v.chk_data = cd; v.dout = dout; v.done = dn; v.busy = bz;
      return v;
   endfunction

   initial begin
      int k;

      //               vld   din           ack   rdy   req   chkd  dout          done  busy
      vecs[0]  = mk(1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
      vecs[2]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
      vecs[3]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
      vecs[4]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1);
      vecs[5]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0);
      vecs[6]  = mk(1'b1, 32'h1,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0);
      vecs[7]  = mk(1'b1, 32'h2,         1'b0, 1'b1, 1'b1, 1'b1, 32'h1,         1'b0, 1'b1);
      vecs[8]  = mk(1'b1, 32'h3,         1'b0, 1'b0, 1'b1, 1'b1, 32'h1,         1'b0, 1'b1);
      vecs[9]  = mk(1'b1, 32'h3,         1'b0, 1'b0, 1'b1, 1'b1, 32'h1,         1'b0, 1'b1);
      vecs[10] = mk(1'b1, 32'h3,         1'b1, 1'b0, 1'b1, 1'b1, 32'h1,         1'b1, 1'b1);
      vecs[11] = mk(1'b1, 32'h3,         1'b1, 1'b1, 1'b1, 1'b1, 32'h2,         1'b1, 1'b1);
      vecs[12] = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h3,         1'b1, 1'b1);
      vecs[13] = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0);
      vecs[14] = mk(1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0);
      vecs[15] = mk(1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0);

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = 32'h0;
      ack         = 1'b0;
      clr_timeout = 1'b0;
      #2;
      check("reset req",     32'(req),      32'h0);
      check("reset done",    32'(done),     32'h0);
      check("reset busy",    32'(busy),     32'h0);
      check("reset timeout", 32'(timeout),  32'h0);
      check("reset ready",   32'(in_ready), 32'h1);
      check("reset data",    data,          32'h0);
      step();
      rst_n = 1'b1;

      // Single handshake, fill to full, back-to-back acks, ack while idle.
      for (int i = 0; i < 16; i++) begin
         in_valid = vecs[i].vld;
         in_data  = vecs[i].din;
         ack      = vecs[i].ack;
         #2;
         $display("vec %0d: vld=%0b din=%h ack=%0b -> rdy=%0b req=%0b data=%h done=%0b busy=%0b",
                  i, in_valid, in_data, ack, in_ready, req, data, done, busy);
         check($sformatf("vec%0d ready", i), 32'(in_ready), 32'(vecs[i].rdy));
         check($sformatf("vec%0d req", i),   32'(req),      32'(vecs[i].req));
         check($sformatf("vec%0d done", i),  32'(done),     32'(vecs[i].done));
         check($sformatf("vec%0d busy", i),  32'(busy),     32'(vecs[i].busy));
         check($sformatf("vec%0d timeout", i), 32'(timeout), 32'h0);
         if (vecs[i].chk_data) check($sformatf("vec%0d data", i), data, vecs[i].dout);
         step();
      end
      in_valid = 1'b0;
      ack      = 1'b0;

      // Timeout: withhold ack, flag must rise 5 cycles after req rises.
      in_valid = 1'b1;
      in_data  = 32'hC0DE_0004;
      #2;
      check("tmo pre req", 32'(req), 32'h0);
      step();
      in_valid = 1'b0;
      #2;
      check("tmo req rise", 32'(req), 32'h1);
      check("tmo data", data, 32'hC0DE_0004);
      k = 0;
      while (timeout !== 1'b1 && k < 20) begin
         step();
         #2;
         k++;
         check("tmo req held", 32'(req), 32'h1);
      end
      $display("timeout seen %0d cycles after req rise", k);
      check("tmo latency", k, 32'd5);
      check("tmo data held", data, 32'hC0DE_0004);

      clr_timeout = 1'b1;
      step();
      clr_timeout = 1'b0;
      #2;
      check("tmo cleared", 32'(timeout), 32'h0);
      check("tmo req after clr", 32'(req), 32'h1);
      for (int i = 0; i < 3; i++) begin
         step();
         #2;
         check("tmo stays clear", 32'(timeout), 32'h0);
      end
      ack = 1'b1;
      #1;
      check("tmo late ack done", 32'(done), 32'h1);
      step();
      ack = 1'b0;
      #2;
      $display("late ack completed: req=%0b busy=%0b", req, busy);
      check("tmo req dropped", 32'(req), 32'h0);
      check("tmo busy dropped", 32'(busy), 32'h0);

      // Reset with two entries queued and req asserted.
      in_valid = 1'b1;
      in_data  = 32'hD000_0001;
      step();
      in_data  = 32'hD000_0002;
      step();
      in_valid = 1'b0;
      #2;
      check("rst pre req", 32'(req), 32'h1);
      check("rst pre ready", 32'(in_ready), 32'h0);
      check("rst pre data", data, 32'hD000_0001);
      rst_n = 1'b0;
      ack   = 1'b1;
      #1;
      $display("mid-handshake reset: req=%0b done=%0b busy=%0b rdy=%0b data=%h",
               req, done, busy, in_ready, data);
      check("rst req",     32'(req),      32'h0);
      check("rst done",    32'(done),     32'h0);
      check("rst busy",    32'(busy),     32'h0);
      check("rst timeout", 32'(timeout),  32'h0);
      check("rst ready",   32'(in_ready), 32'h1);
      check("rst data",    data,          32'h0);
      step();
      ack   = 1'b0;
      rst_n = 1'b1;
      #2;
      check("post rst ready", 32'(in_ready), 32'h1);
      check("post rst busy",  32'(busy),     32'h0);
      step();
      #2;
      check("post rst no req", 32'(req), 32'h0);
      check("post rst no done", 32'(done), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
